reg_wb_arbiter: RTL and testbench

Write-back arbiter that owns the register-file write port (RegWrite/RDaddr/RDdata) in the pipelined MIPS core. It merges results from the in-order pipeline's WB stage and from the iterative multiply/divide unit, which finishes at unpredictable times, through a small FIFO. It drives one registered write per cycle; the register file captures that write on the following negedge.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 53 +++++
 rtl/reg_wb_arbiter.sv | 115 +++++++++++
 tb/tb_reg_wb_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back path.
//   DATA_W / ADDR_W : register data and address widths
//   wb_req_t        : one pending register write {addr, data}
//   is_zero_reg()   : true for $zero, which is never written
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of wb_req_t holding long-latency unit results.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   i_push       : write i_wdata at the tail (caller guarantees not full)
//   i_pop        : drop the head (caller guarantees not empty)
//   o_head       : current head entry, valid while o_count != 0
//   o_count      : occupancy, 0..DEPTH
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_push,
    input  logic             i_pop,
    input  wb_req_t          i_wdata,
    output wb_req_t          o_head,
    output logic [CNT_W-1:0] o_count
);

    wb_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read below r_count.
    always_ff @(posedge clk_i) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Owner of the register-file write port. Each cycle it writes either the
// WB-stage result (highest priority, cannot stall) or the oldest queued
// mul/div result. The write port is registered; the register file samples
// it on the following negedge.
//   clk_i, rst_i                      : clock, async active-high reset
//   pipe_valid_i/addr_i/data_i        : WB stage result
//   lu_valid_i/addr_i/data_i, lu_ready_o : mul/div result handshake
//   RegWrite_o, RDaddr_o, RDdata_o    : register-file write port
//   hold_o                            : ask hazard unit for one WB bubble
//   count_o                           : queued mul/div results
module reg_wb_arbiter #(
    parameter  int DATA_W     = wb_pkg::DATA_W,
    parameter  int ADDR_W     = wb_pkg::ADDR_W,
    parameter  int DEPTH      = 2,
    parameter  int STARVE_MAX = 4,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pipe_valid_i,
    input  logic [ADDR_W-1:0] pipe_addr_i,
    input  logic [DATA_W-1:0] pipe_data_i,
    input  logic              lu_valid_i,
    input  logic [ADDR_W-1:0] lu_addr_i,
    input  logic [DATA_W-1:0] lu_data_i,
    output logic              lu_ready_o,
    output logic              RegWrite_o,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o,
    output logic              hold_o,
    output logic [CNT_W-1:0]  count_o
);

    import wb_pkg::*;

    localparam int AGE_W = $clog2(STARVE_MAX + 1);

    wb_req_t          w_pipe_req;
    wb_req_t          w_lu_req;
    wb_req_t          w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_fifo_empty;
    logic             w_lu_ready;
    logic             w_pipe_wr;
    logic             w_push;
    logic             w_pop;
    logic [AGE_W-1:0] w_age_nxt;
    logic [AGE_W-1:0] r_age;

    assign w_pipe_req.addr = pipe_addr_i;
    assign w_pipe_req.data = pipe_data_i;
    assign w_lu_req.addr   = lu_addr_i;
    assign w_lu_req.data   = lu_data_i;

    assign w_fifo_empty = (w_count == '0);

    // Ready looks only at registered occupancy, so a same-cycle pop never
    // opens a slot for a same-cycle push.
    assign w_lu_ready = (w_count < CNT_W'(DEPTH)) && !rst_i;

    // A write to $zero is a no-op: the pipe slot counts as idle and an
    // accepted $zero mul/div result is simply swallowed.
    assign w_pipe_wr = pipe_valid_i && !is_zero_reg(w_pipe_req.addr);
    assign w_push    = lu_valid_i && w_lu_ready && !is_zero_reg(w_lu_req.addr);

    // Pop decision uses the pre-edge count, so an entry pushed into an
    // empty FIFO waits at least one cycle.
    assign w_pop = !w_pipe_wr && !w_fifo_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_lu_req),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Age of the current head: how long it has been blocked by the pipe.
    always_comb begin
        w_age_nxt = r_age;
        if (w_fifo_empty || w_pop)
            w_age_nxt = '0;
        else if (r_age != AGE_W'(STARVE_MAX))
            w_age_nxt = r_age + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            RegWrite_o <= 1'b0;
            RDaddr_o   <= '0;
            RDdata_o   <= '0;
            r_age      <= '0;
            hold_o     <= 1'b0;
        end else begin
            RegWrite_o <= w_pipe_wr || w_pop;
            // Address/data hold their last value on idle cycles.
            if (w_pipe_wr) begin
                RDaddr_o <= w_pipe_req.addr;
                RDdata_o <= w_pipe_req.data;
            end else if (w_pop) begin
                RDaddr_o <= w_head.addr;
                RDdata_o <= w_head.data;
            end
            r_age  <= w_age_nxt;
            // Raised one cycle early so the bubble lands before saturation.
            hold_o <= (w_age_nxt >= AGE_W'(STARVE_MAX - 1));
        end
    end

    assign lu_ready_o = w_lu_ready;
    assign count_o    = w_count;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;

    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_addr = '0;
    logic [31:0] pipe_data = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_addr = '0;
    logic [31:0] lu_data = '0;
    logic        lu_ready;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        hold;
    logic [1:0]  count;

    int checks = 0;
    int fails  = 0;

    // Reference model: a queue plus the expected write-port contents.
    ent_t        q[$];
    int          m_age  = 0;
    bit          m_we   = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    bit          m_hold = 0;
    bit          cmp_en = 0;

    logic [31:0] rf [32];

    always #5 clk = ~clk;

    reg_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pipe_valid_i (pipe_valid),
        .pipe_addr_i  (pipe_addr),
        .pipe_data_i  (pipe_data),
        .lu_valid_i   (lu_valid),
        .lu_addr_i    (lu_addr),
        .lu_data_i    (lu_data),
        .lu_ready_o   (lu_ready),
        .RegWrite_o   (reg_write),
        .RDaddr_o     (rd_addr),
        .RDdata_o     (rd_data),
        .hold_o       (hold),
        .count_o      (count)
    );

    // Register file sampling the write port on the negedge.
    always @(negedge clk) if (reg_write) rf[rd_addr] <= rd_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_we",    64'(reg_write), 64'(m_we));
            chk("m_addr",  64'(rd_addr),   64'(m_addr));
            chk("m_data",  64'(rd_data),   64'(m_data));
            chk("m_hold",  64'(hold),      64'(m_hold));
            chk("m_count", 64'(count),     64'(q.size()));
            chk("m_ready", 64'(lu_ready),  64'(q.size() < DEPTH));
        end
    end

    task automatic model_reset();
        q.delete();
        m_age = 0; m_we = 0; m_addr = '0; m_data = '0; m_hold = 0;
    endtask

    // Drive one cycle of inputs (just after a negedge), predict the result
    // of the coming posedge, then return 1 time unit past the next negedge.
    task automatic step(input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                        input bit lv, input logic [4:0] la, input logic [31:0] ld);
        int   pre;
        bit   acc;
        bit   popd;
        ent_t e;
        pipe_valid = pv; pipe_addr = pa; pipe_data = pd;
        lu_valid = lv;   lu_addr = la;   lu_data = ld;
        pre  = q.size();
        acc  = lv && (pre < DEPTH);
        popd = 0;
        if (pv && pa != 0) begin
            m_we = 1; m_addr = pa; m_data = pd;
        end else if (pre > 0) begin
            e = q.pop_front();
            m_we = 1; m_addr = e.a; m_data = e.d; popd = 1;
        end else begin
            m_we = 0;
        end
        if (pre == 0 || popd) m_age = 0;
        else if (m_age < STARVE) m_age++;
        m_hold = (m_age >= STARVE - 1);
        if (acc && la != 0) q.push_back('{la, ld});
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        model_reset();
        #22 rst = 1'b0;
        cmp_en = 1;
        @(negedge clk); #1;

        // Reset state
        chk("rst_we",    64'(reg_write), 64'd0);
        chk("rst_count", 64'(count),     64'd0);
        chk("rst_ready", 64'(lu_ready),  64'd1);
        chk("rst_hold",  64'(hold),      64'd0);

        // Pipe only
        step(1, 5'd8, 32'h1234, 0, 0, 0);
        chk("pipe_we",   64'(reg_write), 64'd1);
        chk("pipe_addr", 64'(rd_addr),   64'd8);
        chk("pipe_data", 64'(rd_data),   64'h1234);
        chk("rf8",       64'(rf[8]),     64'h1234);
        step(1, 5'd0, 32'h55, 0, 0, 0);
        chk("pipe0_we",  64'(reg_write), 64'd0);
        chk("pipe0_hold_addr", 64'(rd_addr), 64'd8);

        // Priority and starvation
        step(0, 0, 0, 1, 5'd3, 32'hAA);
        chk("pri_count", 64'(count), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            step(1, 5'd4, 32'(k), 0, 0, 0);
            chk("pri_addr", 64'(rd_addr), 64'd4);
            chk("pri_hold", 64'(hold), 64'(k >= 3));
        end
        step(0, 0, 0, 0, 0, 0);
        chk("pri_pop_addr", 64'(rd_addr), 64'd3);
        chk("pri_pop_data", 64'(rd_data), 64'hAA);
        chk("pri_pop_hold", 64'(hold),    64'd0);

        // Full / back-pressure, order preserved, simultaneous push+pop
        step(1, 5'd5, 32'h1, 1, 5'd10, 32'h111);
        step(1, 5'd5, 32'h2, 1, 5'd11, 32'h222);
        chk("full_count", 64'(count),    64'd2);
        chk("full_ready", 64'(lu_ready), 64'd0);
        step(1, 5'd5, 32'h3, 1, 5'd12, 32'h333);
        chk("full_held", 64'(count), 64'd2);
        step(0, 0, 0, 1, 5'd12, 32'h333);
        chk("ord1_addr", 64'(rd_addr),  64'd10);
        chk("ord1_data", 64'(rd_data),  64'h111);
        chk("ord1_ready", 64'(lu_ready), 64'd1);
        step(0, 0, 0, 1, 5'd12, 32'h333);
        chk("ord2_addr", 64'(rd_addr), 64'd11);
        chk("sim_count", 64'(count),   64'd1);
        step(0, 0, 0, 0, 0, 0);
        chk("ord3_addr", 64'(rd_addr), 64'd12);
        chk("ord3_data", 64'(rd_data), 64'h333);

        // Zero-register lu result
        step(1, 5'd5, 32'h5, 1, 5'd0, 32'hDEAD);
        chk("z_count", 64'(count), 64'd0);
        step(0, 0, 0, 1, 5'd0, 32'hBEEF);
        chk("z_we",    64'(reg_write), 64'd0);
        chk("z_count2", 64'(count), 64'd0);

        // Reset mid-operation with one queued entry
        step(1, 5'd6, 32'h66, 1, 5'd9, 32'h99);
        chk("mr_pre_count", 64'(count), 64'd1);
        pipe_valid = 0; lu_valid = 0;
        cmp_en = 0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("mr_we",    64'(reg_write), 64'd0);
        chk("mr_addr",  64'(rd_addr),   64'd0);
        chk("mr_data",  64'(rd_data),   64'd0);
        chk("mr_count", 64'(count),     64'd0);
        chk("mr_ready", 64'(lu_ready),  64'd0);
        @(posedge clk); #1;
        chk("mr_ready_hold", 64'(lu_ready), 64'd0);
        #2 rst = 1'b0;
        #1;
        chk("mr_ready_rel", 64'(lu_ready), 64'd1);
        cmp_en = 1;
        @(negedge clk); #1;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] pa, la;
            pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            la = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(($urandom_range(0, 99) < 55), pa, $urandom,
                 ($urandom_range(0, 99) < 45), la, $urandom);
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
